// File: rtl/addsub_pipe_32bit.sv
// addsub_pipe_32bit: 32-bit adder/subtractor feeding a 2-entry in-order
// output buffer with valid/ready handshakes on both sides.
// Optional feature: define ADDSUB_PIPE_FLAGS_EN to add the {ovf, neg, zero}
// flags port and per-entry flag storage.
module addsub_pipe_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        c_out,
`ifdef ADDSUB_PIPE_FLAGS_EN
  output logic [2:0]  flags,
`endif
  output logic [15:0] op_count
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

`ifdef ADDSUB_PIPE_FLAGS_EN
  // Signed overflow of x + y_eff (+cin): both operands share a sign and the
  // result sign differs. y_eff is already inverted for subtraction.
  function automatic logic ovf_detect(input logic signed [DATA_W-1:0] x,
                                      input logic signed [DATA_W-1:0] y_eff,
                                      input logic signed [DATA_W-1:0] r);
    return (x[DATA_W-1] == y_eff[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
  endfunction
`endif

  // ---- stage p0: operand arithmetic (combinational, at acceptance) ----
  logic [DATA_W-1:0]        b_eff_p0;
  logic [DATA_W:0]          sum_p0;
  logic signed [DATA_W-1:0] res_p0;
  logic                     cout_p0;
  logic                     vld_p0;

  // Two's-complement subtract is a + ~b + 1; sel doubles as the carry-in.
  always_comb begin
    b_eff_p0 = b ^ {DATA_W{sel}};
    sum_p0   = {1'b0, a} + {1'b0, b_eff_p0} + {{DATA_W{1'b0}}, sel};
    res_p0   = $signed(sum_p0[DATA_W-1:0]);
    cout_p0  = sum_p0[DATA_W];
  end

`ifdef ADDSUB_PIPE_FLAGS_EN
  logic [2:0] flags_p0;

  // Flags are computed alongside the sum so each entry carries its own.
  always_comb begin
    flags_p0 = {ovf_detect($signed(a), $signed(b_eff_p0), res_p0),
                res_p0[DATA_W-1],
                (res_p0 == '0)};
  end
`endif

  // ---- stage p1: 2-entry output buffer ----
  logic [1:0]               count;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic                     vld_p1;
  logic                     pop;
  logic signed [DATA_W-1:0] res_p1  [2];
  logic                     cout_p1 [2];
`ifdef ADDSUB_PIPE_FLAGS_EN
  logic [2:0]               flags_p1 [2];
`endif

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready = (count != 2'd2);
  assign vld_p0   = in_valid && in_ready;
  assign vld_p1   = (count != 2'd0);
  assign pop      = vld_p1 && out_ready;

  // Occupancy, pointers and op counter; reset discards every entry at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      op_count <= '0;
    end else begin
      case ({vld_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (vld_p0) begin
        wr_ptr   <= ~wr_ptr;
        op_count <= sat_inc(op_count);
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Entry storage is data only; occupancy decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (vld_p0 && rst_n) begin
      res_p1[wr_ptr]   <= res_p0;
      cout_p1[wr_ptr]  <= cout_p0;
`ifdef ADDSUB_PIPE_FLAGS_EN
      flags_p1[wr_ptr] <= flags_p0;
`endif
    end
  end

  // Head entry is shown only while the buffer holds something, so stale
  // storage never leaks out after a pop or a reset.
  always_comb begin
    out_valid = vld_p1;
    result    = vld_p1 ? res_p1[rd_ptr] : '0;
    c_out     = vld_p1 ? cout_p1[rd_ptr] : 1'b0;
`ifdef ADDSUB_PIPE_FLAGS_EN
    flags     = vld_p1 ? flags_p1[rd_ptr] : 3'b000;
`endif
  end

endmodule

// File: tb/tb_addsub_pipe_32bit.sv
// Scoreboard bench for addsub_pipe_32bit: accepted operations push the
// reference result into a queue; a negedge monitor compares the buffer head.
// Flag checks are active when ADDSUB_PIPE_FLAGS_EN is defined.
module tb_addsub_pipe_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        c_out;
  logic [15:0] op_count;
`ifdef ADDSUB_PIPE_FLAGS_EN
  logic [2:0]  flags;
`endif

  addsub_pipe_32bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .c_out(c_out),
`ifdef ADDSUB_PIPE_FLAGS_EN
    .flags(flags),
`endif
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic [2:0]  f;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  bit   acc_pend = 0;
  exp_t pend;

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t ref_model(logic [31:0] x, logic [31:0] y, logic s);
    exp_t e;
    longint unsigned ux, uy, t;
    longint sx, sy, sf;
    ux = x;
    uy = y;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      t   = ux + uy;
      e.r = t[31:0];
      e.c = t[32];
      sf  = sx + sy;
    end else begin
      e.r = x - y;
      e.c = (x >= y);
      sf  = sx - sy;
    end
    e.f[2] = (sf > 64'sd2147483647) || (sf < -64'sd2147483648);
    e.f[1] = e.r[31];
    e.f[0] = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Note what the DUT will accept at the coming edge.
  always @(negedge clk) begin
    acc_pend = (in_valid === 1'b1) && (in_ready === 1'b1);
    pend     = ref_model(a, b, sel);
  end

  // Model update at the clock edge: reset clears, acceptance pushes.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      q.delete();
      mcnt = 0;
    end else if (acc_pend) begin
      q.push_back(pend);
      if (mcnt < 65535) mcnt++;
    end
  end

  // Monitor: compare handshake state and head entry, pop on consumer accept.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      chk("op_count", {16'd0, op_count}, mcnt);
      if (q.size() != 0) begin
        chk("result", result, q[0].r);
        chk("c_out", {31'd0, c_out}, {31'd0, q[0].c});
`ifdef ADDSUB_PIPE_FLAGS_EN
        chk("flags", {29'd0, flags}, {29'd0, q[0].f});
`endif
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("result_idle", result, 32'd0);
        chk("c_out_idle", {31'd0, c_out}, 32'd0);
`ifdef ADDSUB_PIPE_FLAGS_EN
        chk("flags_idle", {29'd0, flags}, 32'd0);
`endif
      end
    end
  end

  // Present one operation and hold it until accepted (bounded wait).
  task automatic send(logic [31:0] x, logic [31:0] y, logic s);
    bit ok = 0;
    a = x;
    b = y;
    sel = s;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got=not_accepted exp=accepted at %0t", $time);
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0000_0000;
    sp[1] = 32'h0000_0001;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h7FFF_FFFF;
    sp[4] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  bit rnd_done = 0;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sel = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    started = 1;

    // Directed arithmetic corner cases.
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    idle(1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    idle(1);
    send(32'd3, 32'd5, 1'b1);
    idle(1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle(1);
    send(32'h0000_0000, 32'h8000_0000, 1'b1);
    idle(2);

    // Backpressure: buffer fills after two, third waits for out_ready.
    do_reset(1);
    out_ready = 1'b0;
    fork
      begin
        send(32'd1, 32'd1, 1'b0);
        send(32'd2, 32'd2, 1'b0);
        send(32'd3, 32'd3, 1'b0);
      end
      begin
        idle(6);
        out_ready = 1'b1;
      end
    join
    idle(4);
    @(negedge clk);
    chk("op_count_bp", {16'd0, op_count}, 32'd3);
    @(posedge clk);
    #1;

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(32'd10, 32'd20, 1'b0);
    send(32'd30, 32'd40, 1'b1);
    do_reset(1);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);

    // in_valid held high throughout a reset must not be accepted.
    a = 32'd9;
    b = 32'd9;
    sel = 1'b0;
    in_valid = 1'b1;
    do_reset(2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ignore_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_ignore_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(pick(), pick(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;

    // Drain with a bound.
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsub_pipe_32bit.md
ADDSUB_PIPE_32BIT -- requirements
Module: addsub_pipe_32bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept an operand set this cycle
- sel  input  1  0 = add, 1 = subtract (a - b)
- a  input  32  operand A
- b  input  32  operand B
- out_valid  output  1  result entry present
- out_ready  input  1  consumer accepts the head entry
- result  output  32  head-entry sum or difference
- c_out  output  1  head-entry carry out; for subtract, 1 = no borrow
- flags  output  3  head-entry {ovf, neg, zero}; present only under the configuration macro
- op_count  output  16  saturating count of accepted operations
REQ-003 The block SHALL have no parameters; the width is fixed at 32.

Function
REQ-004 The block SHALL compute {c_out, result} = a + (b XOR {32{sel}}) + sel, modulo 2^33.
REQ-005 An operation SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-006 The computed entry SHALL be written into a 2-entry in-order output buffer at acceptance.
REQ-007 out_valid SHALL assert on the cycle after acceptance, giving 1-cycle latency into an empty buffer.
REQ-008 The head entry SHALL be popped when out_valid && out_ready at a rising edge.
REQ-009 result, c_out and flags SHALL hold steady while out_valid && !out_ready.
REQ-010 in_ready SHALL equal (count != 2), where count is the buffer occupancy 0..2; in_ready SHALL NOT depend combinationally on out_ready.
REQ-011 When a push and a pop occur in the same cycle, count SHALL be unchanged and entry order SHALL be preserved.
REQ-012 A push SHALL NOT occur when count = 2, and a pop SHALL NOT occur when count = 0.
REQ-013 Read and write pointers SHALL be 1 bit each and SHALL wrap from 1 to 0.
REQ-014 op_count SHALL increment by 1 on each acceptance and SHALL saturate at 0xFFFF.
REQ-015 When count = 0, result and c_out SHALL be 0 and out_valid SHALL be 0.

Reset
REQ-016 While rst_n = 0 at a rising edge, count, both pointers and op_count SHALL be cleared.
REQ-017 After that reset edge, out_valid, result, c_out and flags SHALL all be 0, and in_ready SHALL be 1.
REQ-018 A reset asserted mid-operation SHALL discard all buffered entries with no partial pop.
REQ-019 in_valid SHALL be ignored during any cycle in which rst_n = 0.

Configuration
REQ-020 When ADDSUB_PIPE_FLAGS_EN is defined, the flags port SHALL exist, and each buffer entry SHALL store:
- zero = (result == 0)
- neg = result[31]
- ovf = signed overflow of the operation selected by sel
REQ-021 When ADDSUB_PIPE_FLAGS_EN is undefined, the flags port and its storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover at least these scenarios:
- Add: a=0x00000005, b=0x00000003, sel=0 -> next cycle out_valid=1, result=0x00000008, c_out=0, flags=000.
- Wrap to zero: a=0xFFFFFFFF, b=0x00000001, sel=0 -> result=0x00000000, c_out=1, flags=001.
- Subtract with borrow: a=3, b=5, sel=1 -> result=0xFFFFFFFE, c_out=0, flags=010.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sel=0 -> result=0x80000000, c_out=0, flags=110.
- Backpressure: out_ready=0, then present ops 1+1, 2+2, 3+3 back-to-back -> in_ready=0 after two acceptances; raise out_ready -> outputs 2, 4, then the third op accepted yields 6, in order; op_count=3.
- Reset mid-operation: two entries buffered, then rst_n=0 for 1 cycle -> out_valid=0, in_ready=1, op_count=0, and no stale entries appear afterwards.
